// File: rtl/serial_subtractor_4bits_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_subtractor_4bits_pkg;

  // Default operand/result width of the serial subtractor.
  localparam int WIDTH_DEFAULT = 4;

  // Controller states. The unused code 2'd3 is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Width of the bit counter for a given operand width (at least one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_4bits_full_subtractor.sv
// One-bit subtract cells: a half subtractor and a full subtractor built from
// two half subtractors plus an OR gate, mirroring the half/full adder pair.

// Half subtractor: difference and borrow of a - b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  // a - b on single bits: borrow only when a = 0 and b = 1.
  always_comb begin
    diff   = a ^ b;
    borrow = ~a & b;
  end

endmodule

// Full subtractor: bit0 = a - b - received, sent_bit = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic received,
  output logic sent_bit,
  output logic bit0
);

  logic d_first;
  logic borrow_first;
  logic borrow_second;

  // First stage subtracts b from a.
  half_subtractor u_hs_ab (
    .a      (a),
    .b      (b),
    .diff   (d_first),
    .borrow (borrow_first)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs_br (
    .a      (d_first),
    .b      (received),
    .diff   (bit0),
    .borrow (borrow_second)
  );

  // At most one stage can borrow, so OR merges them into the borrow out.
  always_comb begin
    sent_bit = borrow_first | borrow_second;
  end

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB first, one bit per
// clock, through a single full subtractor and a borrow flip-flop. A
// start/busy/done handshake allows back-to-back operations.
module serial_subtractor_4bits
  import serial_subtractor_4bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             sent_borrow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;

  // The single subtract cell works on the current LSBs and the stored borrow.
  full_subtractor u_full_subtractor (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .received (br),
    .sent_bit (br_next),
    .bit0     (d_bit)
  );

  // Result and borrow are exposed directly; they hold until the next start.
  assign diff        = diff_sh;
  assign sent_borrow = br;

  // Controller, operand shifters, result shifter, borrow flop and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      br      <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_SHIFT: begin
          diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          br      <= br_next;
          cnt     <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE, DONE and the unused code all accept a new request;
          // without one, DONE and the unused code fall back to IDLE.
          if (start) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            done    <= 1'b0;
            a_sh    <= a;
            b_sh    <= b;
            br      <= borrow_in;
            diff_sh <= '0;
            cnt     <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Self-checking bench for serial_subtractor_4bits: a transaction-level model
// predicts busy/done and the final {borrow, diff} from plain arithmetic.
module tb_serial_subtractor_4bits;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             borrow_in = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             sent_borrow;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor_4bits #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .borrow_in   (borrow_in),
    .busy        (busy),
    .done        (done),
    .diff        (diff),
    .sent_borrow (sent_borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted request yields {0,a}-b-bin after WIDTH edges.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bo = 1'b0;
  logic [WIDTH:0]   m_pend = '0;
  int               m_left = 0;
  int               m_completed = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_diff = '0;
      m_bo   = 1'b0;
      m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_bo, m_diff} = m_pend;
        m_completed++;
      end
    end else if (start) begin
      m_pend = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = WIDTH;
    end else begin
      m_done = 1'b0;
    end
  end

  // Cycle compare: handshake always, result whenever no operation is running.
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (!m_busy) begin
      check("diff", diff, m_diff);
      check("sent_borrow", sent_borrow, m_bo);
    end
  end

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic bin, input logic st);
    a = av;
    b = bv;
    borrow_in = bin;
    start = st;
  endtask

  // Waits (bounded) for a negedge where done is high; returns cycles waited.
  task automatic wait_done(output int cycles, output logic ok);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    ok = (done === 1'b1);
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Directed operation with hand-computed expectations for DUT and model.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic bin,
                        input logic [3:0] exp_d, input logic exp_bo, input string tag);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    #2 drive(av, bv, bin, 1'b1);
    @(negedge clk);
    #2 drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, sent_borrow, exp_bo);
    check({tag, "_model"}, {m_bo, m_diff}, {exp_bo, exp_d});
  endtask

  initial begin
    int cyc;
    logic ok;
    int sweep_dones;
    logic saw_done;

    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_diff", diff, 4'h0);
    check("reset_borrow", sent_borrow, 1'b0);
    #1 rst_n = 1'b1;

    run_op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, "t7m3");
    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "t3m5");
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "t0m0b");

    // 15-15, then start held high with new operands through busy.
    @(negedge clk);
    #2 drive(4'b1111, 4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    #2 drive(4'b0101, 4'b0011, 1'b0, 1'b1);
    wait_done(cyc, ok);
    check("held_first_latency", cyc, 4);
    check("held_first_diff", diff, 4'b0000);
    check("held_first_borrow", sent_borrow, 1'b0);
    @(negedge clk);
    #1;
    check("held_b2b_busy", busy, 1'b1);
    check("held_b2b_done", done, 1'b0);
    #1 start = 1'b0;
    wait_done(cyc, ok);
    check("held_second_latency", cyc, 4);
    check("held_second_diff", diff, 4'b0010);
    check("held_second_borrow", sent_borrow, 1'b0);

    // Reset two edges into an operation.
    @(negedge clk);
    #2 drive(4'b1001, 4'b0010, 1'b0, 1'b1);
    @(negedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, 4'h0);
    check("midrst_borrow", sent_borrow, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);

    // Exhaustive back-to-back sweep: each request issued on the done cycle.
    sweep_dones = 0;
    for (int i = 0; i < 512; i++) begin
      #2 drive(4'(i[8:5]), 4'(i[4:1]), i[0], 1'b1);
      @(negedge clk);
      #2 drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      wait_done(cyc, ok);
      if (ok) sweep_dones++;
      if (!ok) break;
    end
    check("sweep_done_count", sweep_dones, 512);

    // Randomized requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #2;
      drive(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    #2 drive(4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
